// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-outstanding AXI4 initiator that turns one local
// command into one INCR burst. It streams write data in from wd_*, returns
// read data on rd_*, and ends every command with a one-cycle done pulse.
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // local write-data stream
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    // local read-data stream
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    // AXI write address
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI write data
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // AXI write response
    input  logic [1:0]            BRESP,
    input  logic                  BVAILD,
    output logic                  BREADY,
    // AXI read address
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // AXI read data
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVAILD,
    output logic                  RREADY
);

    localparam int SZ = $clog2(DATA_WIDTH / 8);
    // wide enough that the burst end address never wraps
    localparam int EW = ADDR_WIDTH + 16;
    localparam logic [2:0] SIZE_ENC = 3'(SZ);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << SZ) - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_ERR} state_t;

    state_t                state, state_n;
    logic                  done_n;
    logic [1:0]            resp_n;
    logic [7:0]            len_q;
    logic [8:0]            fetched;
    logic [8:0]            rbeats;
    logic [1:0]            acc_resp;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [EW-1:0]         start_ext;
    logic [EW-1:0]         end_ext;
    logic                  crosses;
    logic                  cmd_hs;
    logic                  wd_hs;
    logic                  w_hs;
    logic                  r_hs;

    // AXI responses are ordered by severity, so the worst one is the larger code
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign start_addr = cmd_addr & ALIGN_MASK;
    assign start_ext  = EW'(start_addr);
    assign end_ext    = start_ext + (EW'({1'b0, cmd_len} + 9'd1) << SZ) - EW'(1);
    assign crosses    = (start_ext[EW-1:12] != end_ext[EW-1:12]);

    // cmd_ready stays low while done is shown so the completion is seen first
    assign cmd_ready = (state == ST_IDLE) && !done && !ARESET;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign wd_ready  = (state == ST_W) && (!WVALID || WREADY) && (fetched <= {1'b0, len_q});
    assign wd_hs     = wd_valid && wd_ready;
    assign w_hs      = WVALID && WREADY;
    assign BREADY    = (state == ST_B);
    assign RREADY    = (state == ST_R) && rd_ready;
    assign r_hs      = RVAILD && RREADY;
    assign rd_valid  = (state == ST_R) && RVAILD;
    assign rd_data   = (state == ST_R) ? RDATA : '0;
    assign rd_last   = (state == ST_R) && RLAST;

    // Next-state and completion decode
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        resp_n  = done_resp;
        case (state)
            ST_IDLE: begin
                if (cmd_hs) begin
                    if (crosses) begin
                        state_n = ST_ERR;
                        done_n  = 1'b1;
                        resp_n  = 2'b10;
                    end else begin
                        state_n = cmd_write ? ST_AW : ST_AR;
                    end
                end
            end
            ST_ERR: state_n = ST_IDLE;
            ST_AW:  if (AWVALID && AWREADY) state_n = ST_W;
            ST_W:   if (w_hs && WLAST) state_n = ST_B;
            ST_B: begin
                if (BVAILD) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    resp_n  = BRESP;
                end
            end
            ST_AR:  if (ARVALID && ARREADY) state_n = ST_R;
            ST_R: begin
                if (r_hs && RLAST) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    // an RLAST on any beat other than len+1 is a protocol error
                    resp_n  = (rbeats != {1'b0, len_q}) ? 2'b10 : resp_max(acc_resp, RRESP);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and registered completion pulse
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            state     <= state_n;
            done      <= done_n;
            done_resp <= resp_n;
        end
    end

    // Address channels: load on command accept, hold until the READY handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            len_q   <= '0;
            AWVALID <= 1'b0;
            AWADDR  <= '0;
            AWLEN   <= '0;
            AWSIZE  <= '0;
            ARVALID <= 1'b0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            ARSIZE  <= '0;
        end else begin
            if (cmd_hs) begin
                len_q <= cmd_len;
                if (!crosses) begin
                    if (cmd_write) begin
                        AWVALID <= 1'b1;
                        AWADDR  <= start_addr;
                        AWLEN   <= cmd_len;
                        AWSIZE  <= SIZE_ENC;
                    end else begin
                        ARVALID <= 1'b1;
                        ARADDR  <= start_addr;
                        ARLEN   <= cmd_len;
                        ARSIZE  <= SIZE_ENC;
                    end
                end
            end
            if (AWVALID && AWREADY) AWVALID <= 1'b0;
            if (ARVALID && ARREADY) ARVALID <= 1'b0;
        end
    end

    // Write-data skid: refill on the same cycle WREADY drains for 1 beat/cycle
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            WVALID  <= 1'b0;
            WDATA   <= '0;
            WLAST   <= 1'b0;
            fetched <= '0;
        end else if (cmd_hs) begin
            fetched <= '0;
        end else if (wd_hs) begin
            WDATA   <= wd_data;
            WVALID  <= 1'b1;
            WLAST   <= (fetched == {1'b0, len_q});
            fetched <= fetched + 9'd1;
        end else if (w_hs) begin
            WVALID  <= 1'b0;
            WLAST   <= 1'b0;
        end
    end

    // Read beat count and worst-case response accumulation
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rbeats   <= '0;
            acc_resp <= 2'b00;
        end else if (cmd_hs) begin
            rbeats   <= '0;
            acc_resp <= 2'b00;
        end else if (r_hs) begin
            rbeats   <= rbeats + 9'd1;
            // beat len+1 without RLAST poisons the response; keep waiting for RLAST
            acc_resp <= (!RLAST && rbeats == {1'b0, len_q}) ? 2'b10 : resp_max(acc_resp, RRESP);
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: directed + randomized bench with a behavioural AXI
// slave, a local stream source/sink and a burst-level reference model.
module tb_axi4_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY = 1'b0, ARVALID, ARREADY = 1'b0;
    logic [31:0] WDATA, RDATA = '0;
    logic        WLAST, WVALID, WREADY = 1'b0;
    logic [1:0]  BRESP = '0, RRESP = '0;
    logic        BVAILD = 1'b0, BREADY;
    logic        RLAST = 1'b0, RVAILD = 1'b0, RREADY;

    axi4_burst_master dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVAILD(BVAILD), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVAILD(RVAILD), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    // slave / stream configuration
    int          wr_mode = 0;      // 0 always ready, 1 fixed pattern, 2 random
    bit          wd_gap = 0;
    bit          addr_rand = 0;
    int          rdr_mode = 0;     // 0 always, 1 toggle, 2 random
    logic [1:0]  cfg_bresp = 2'b00;
    bit          wr_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    // stimulus queues and observations
    logic [31:0] wd_q[$];
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic        rq_last[$];
    logic [31:0] obs_w[$];
    logic        obs_wl[$];
    logic [31:0] obs_rd[$];
    logic        obs_rl[$];
    int          aw_cnt = 0, ar_cnt = 0, done_cnt = 0, stab_err = 0, pt_err = 0, aw_valid_cycles = 0;
    logic [15:0] aw_addr = '0, ar_addr = '0;
    logic [7:0]  aw_len = '0, ar_len = '0;
    logic [2:0]  aw_size = '0, ar_size = '0;
    logic [1:0]  last_resp = '0;
    bit          bpending = 0, ractive = 0, prev_wstall = 0, wd_keep = 0;
    logic [31:0] prev_wdata = '0;
    logic        prev_wlast = 1'b0;
    int          wr_idx = 0;

    // Behavioural AXI slave plus local stream endpoints; drives at negedge+1,
    // observes handshakes at negedge+2 (the values the next posedge will see)
    initial begin
        forever begin
            @(negedge ACLK);
            #1;
            if (ARESET) begin
                wd_q.delete(); rq_data.delete(); rq_resp.delete(); rq_last.delete();
                bpending = 0; ractive = 0; prev_wstall = 0; wd_keep = 0;
                AWREADY = 0; ARREADY = 0; WREADY = 0; BVAILD = 0; RVAILD = 0; RLAST = 0;
                wd_valid = 0; rd_ready = 0;
            end else begin
                if (prev_wstall && (WVALID !== 1'b1 || WDATA !== prev_wdata || WLAST !== prev_wlast))
                    stab_err++;
                if (done === 1'b1) begin
                    done_cnt++;
                    last_resp = done_resp;
                end
                if (AWVALID === 1'b1) aw_valid_cycles++;
                AWREADY = addr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                ARREADY = addr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                case (wr_mode)
                    0:       WREADY = 1'b1;
                    1:       WREADY = wr_pat[wr_idx % 7];
                    default: WREADY = 1'($urandom_range(0, 1));
                endcase
                wr_idx++;
                BVAILD = bpending;
                BRESP  = cfg_bresp;
                if (ractive && rq_data.size() > 0) begin
                    RVAILD = 1; RDATA = rq_data[0]; RRESP = rq_resp[0]; RLAST = rq_last[0];
                end else begin
                    RVAILD = 0; RDATA = '0; RRESP = '0; RLAST = 0;
                end
                if (wd_q.size() > 0) begin
                    wd_valid = wd_keep ? 1'b1 : (wd_gap ? ($urandom_range(0, 2) != 0) : 1'b1);
                    wd_data  = wd_q[0];
                end else begin
                    wd_valid = 0;
                    wd_data  = '0;
                end
                case (rdr_mode)
                    0:       rd_ready = 1'b1;
                    1:       rd_ready = ~rd_ready;
                    default: rd_ready = 1'($urandom_range(0, 1));
                endcase
                #1;
                if (AWVALID && AWREADY) begin
                    aw_cnt++; aw_addr = AWADDR; aw_len = AWLEN; aw_size = AWSIZE;
                end
                if (WVALID && WREADY) begin
                    obs_w.push_back(WDATA);
                    obs_wl.push_back(WLAST);
                    if (WLAST) bpending = 1;
                end
                prev_wstall = WVALID && !WREADY;
                prev_wdata  = WDATA;
                prev_wlast  = WLAST;
                wd_keep = wd_valid && !wd_ready;
                if (wd_valid && wd_ready) void'(wd_q.pop_front());
                if (BVAILD && BREADY) bpending = 0;
                if (ARVALID && ARREADY) begin
                    ar_cnt++; ar_addr = ARADDR; ar_len = ARLEN; ar_size = ARSIZE; ractive = 1;
                end
                if (RVAILD && RREADY) begin
                    if (rd_valid !== 1'b1) pt_err++;
                    obs_rd.push_back(rd_data);
                    obs_rl.push_back(rd_last);
                    if (RLAST) ractive = 0;
                    void'(rq_data.pop_front()); void'(rq_resp.pop_front()); void'(rq_last.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] len);
        bit ok;
        ok = 0;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i < 100; i++) begin
            #3;
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge ACLK);
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL cmd_accept: observed timeout expected cmd_ready");
        end
        @(negedge ACLK);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n0;
        bit ok;
        n0 = done_cnt;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge ACLK); #3;
            if (done_cnt != n0) begin ok = 1; break; end
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL %s_done: observed timeout expected done pulse", tag);
        end
        if (ok) begin
            check({tag, "_rdy_during_done"}, cmd_ready, 0);
            @(negedge ACLK); #3;
            check({tag, "_pulse_then_ready"}, {done, cmd_ready}, 2'b01);
            check({tag, "_done_count"}, done_cnt - n0, 1);
        end
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [7:0] len,
                            input int wmode, input bit gap, input logic [1:0] bresp, input bit fixed);
        logic [31:0] exp_d[$];
        logic [15:0] s;
        bit          err;
        int          avc0, aw0, d0;
        s   = addr & 16'hFFFC;
        err = ((int'(s) >> 12) != ((int'(s) + (int'(len) + 1) * 4 - 1) >> 12));
        wr_mode = wmode; wd_gap = gap; cfg_bresp = bresp; addr_rand = (wmode != 0); wr_idx = 0;
        obs_w.delete(); obs_wl.delete(); stab_err = 0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_d.push_back(fixed ? 32'hA0 + 32'(i) : $urandom);
            wd_q.push_back(exp_d[i]);
        end
        aw0 = aw_cnt; avc0 = aw_valid_cycles; d0 = done_cnt;
        issue(1'b1, addr, len);
        #3;
        if (err) begin
            check({tag, "_err_done"}, {done, done_resp}, 3'b110);
            repeat (3) @(negedge ACLK);
            #3;
            check({tag, "_err_no_awvalid"}, aw_valid_cycles - avc0, 0);
            check({tag, "_err_no_fetch"}, wd_q.size(), int'(len) + 1);
            check({tag, "_err_done_count"}, done_cnt - d0, 1);
            wd_q.delete();
        end else begin
            check({tag, "_awvalid_latency"}, AWVALID, 1);
            wait_done(tag, 600);
            check({tag, "_awaddr"}, aw_addr, s);
            check({tag, "_awlen"}, aw_len, len);
            check({tag, "_awsize"}, aw_size, 2);
            check({tag, "_aw_count"}, aw_cnt - aw0, 1);
            check({tag, "_beats"}, obs_w.size(), int'(len) + 1);
            for (int i = 0; i < obs_w.size() && i <= int'(len); i++) begin
                check({tag, "_wdata"}, obs_w[i], exp_d[i]);
                check({tag, "_wlast"}, obs_wl[i], (i == int'(len)));
            end
            check({tag, "_resp"}, last_resp, bresp);
            check({tag, "_w_stable"}, stab_err, 0);
        end
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] len,
                           input int nsend, input int err_beat, input int rmode, input bit rand_resp);
        logic [31:0] exp_d[$];
        logic [1:0]  maxr, r, exp_resp;
        logic [15:0] s;
        int          ar0;
        s = addr & 16'hFFFC;
        rdr_mode = rmode; addr_rand = (rmode != 0);
        obs_rd.delete(); obs_rl.delete(); pt_err = 0;
        maxr = 2'b00;
        for (int i = 0; i < nsend; i++) begin
            r = rand_resp ? 2'($urandom_range(0, 3)) : ((i == err_beat) ? 2'b10 : 2'b00);
            if (r > maxr) maxr = r;
            exp_d.push_back($urandom);
            rq_data.push_back(exp_d[i]);
            rq_resp.push_back(r);
            rq_last.push_back(i == nsend - 1);
        end
        exp_resp = (nsend != int'(len) + 1) ? 2'b10 : maxr;
        ar0 = ar_cnt;
        issue(1'b0, addr, len);
        #3;
        check({tag, "_arvalid_latency"}, ARVALID, 1);
        wait_done(tag, 3000);
        check({tag, "_araddr"}, ar_addr, s);
        check({tag, "_arlen"}, ar_len, len);
        check({tag, "_arsize"}, ar_size, 2);
        check({tag, "_ar_count"}, ar_cnt - ar0, 1);
        check({tag, "_beats"}, obs_rd.size(), nsend);
        for (int i = 0; i < obs_rd.size() && i < nsend; i++) begin
            check({tag, "_rdata"}, obs_rd[i], exp_d[i]);
            check({tag, "_rlast"}, obs_rl[i], (i == nsend - 1));
        end
        check({tag, "_rd_valid_passthru"}, pt_err, 0);
        check({tag, "_resp"}, last_resp, exp_resp);
    endtask

    initial begin
        int d0;
        bit ok;
        // reset state
        repeat (3) @(negedge ACLK);
        #3;
        check("rst_ctrl", {cmd_ready, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY,
                           wd_ready, rd_valid, rd_last, done}, 0);
        check("rst_data", {AWADDR, AWLEN, AWSIZE, ARSIZE, done_resp}, 0);
        check("rst_wdata", WDATA, 0);
        @(negedge ACLK);
        ARESET = 0;
        #3;
        check("rst_release_ready", cmd_ready, 1);

        // basic write, then stalled write with source gaps
        do_write("t1", 16'h0100, 8'd3, 0, 0, 2'b00, 1);
        do_write("t2", 16'h0100, 8'd3, 1, 1, 2'b00, 1);

        // reads with toggling consumer, one SLVERR beat then all OKAY
        do_read("t3a", 16'h0200, 8'd7, 8, 2, 1, 0);
        do_read("t3b", 16'h0200, 8'd7, 8, -1, 1, 0);

        // 4 KB crossing rejected, non-crossing at same base accepted
        do_write("t4a", 16'h0FF0, 8'd7, 0, 0, 2'b00, 0);
        do_write("t4b", 16'h0FF0, 8'd3, 0, 0, 2'b00, 0);

        // reset in the middle of a write burst
        wr_mode = 0; wd_gap = 0; addr_rand = 0; obs_w.delete(); obs_wl.delete();
        for (int i = 0; i < 4; i++) wd_q.push_back($urandom);
        d0 = done_cnt;
        issue(1'b1, 16'h0300, 8'd3);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK); #3;
            if (obs_w.size() >= 1) begin ok = 1; break; end
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL t5_first_beat: observed timeout expected one W beat");
        end
        @(negedge ACLK);
        ARESET = 1;
        @(negedge ACLK);
        #3;
        check("t5_rst_ctrl", {cmd_ready, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY,
                              wd_ready, rd_valid, done}, 0);
        check("t5_rst_data", {AWADDR, AWLEN, AWSIZE}, 0);
        @(negedge ACLK);
        ARESET = 0;
        #3;
        check("t5_release_ready", cmd_ready, 1);
        check("t5_no_done", done_cnt - d0, 0);
        do_read("t5r", 16'h0400, 8'd3, 4, -1, 0, 0);

        // early RLAST, then longest burst
        do_read("t6a", 16'h0300, 8'd3, 2, -1, 0, 0);
        do_read("t6b", 16'h0200, 8'd255, 256, -1, 2, 0);

        // randomized commands
        for (int k = 0; k < 6; k++)
            do_write("rw", 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 0);
        for (int k = 0; k < 5; k++) begin
            int ln;
            ln = int'($urandom_range(0, 15));
            do_read("rr", 16'($urandom_range(0, 14) * 4096 + $urandom_range(0, 63) * 4), 8'(ln),
                    int'($urandom_range(1, ln + 1)), -1, int'($urandom_range(0, 2)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
